// File: rtl/grip_lift_sequencer_pkg.sv
// Shared constants for the grip/lift sequencer and the mission FSM.
// State encoding and default lift duty words live here.
package grip_lift_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPEN    = 3'd1,
    S_LOWER   = 3'd2,
    S_CLOSE   = 3'd3,
    S_RELEASE = 3'd4,
    S_RAISE   = 3'd5
  } gl_state_t;

  localparam int          TW_DEF        = 24;
  localparam logic [13:0] LIFT_UP_DEF   = 14'h2328;
  localparam logic [13:0] LIFT_DOWN_DEF = 14'h1388;

endpackage

// File: rtl/grip_lift_sequencer_if.sv
// Request/status bundle between the mission FSM (master)
// and the grip/lift sequencer (slave).
interface grip_lift_sequencer_if;

  logic        pick_req;
  logic        drop_req;
  logic        abort;
  logic        box_present;
  logic        claw_close;
  logic [13:0] lift_duty;
  logic        busy;
  logic        done;
  logic        fail;
  logic        reject;
  logic        holding;
  logic [2:0]  state_dbg;

  modport master (
    output pick_req, drop_req, abort, box_present,
    input  claw_close, lift_duty, busy, done, fail,
    input  reject, holding, state_dbg
  );

  modport slave (
    input  pick_req, drop_req, abort, box_present,
    output claw_close, lift_duty, busy, done, fail,
    output reject, holding, state_dbg
  );

endinterface

// File: rtl/grip_lift_sequencer_seq_timer.sv
// Down-counter shared by every timed state: load, count to zero,
// then hold at zero until reloaded.
module seq_timer #(
  parameter int TW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/grip_lift_sequencer.sv
// Sequences claw servo and lift PWM through pick-up and drop-off
// manoeuvres on one-shot requests from the mission FSM.
module grip_lift_sequencer
  import grip_lift_sequencer_pkg::*;
#(
  parameter int          TW        = TW_DEF,
  parameter logic [TW-1:0] CLAW_T  = 24'd5_000_000,
  parameter logic [TW-1:0] LIFT_T  = 24'd10_000_000,
  parameter logic [13:0] LIFT_UP   = LIFT_UP_DEF,
  parameter logic [13:0] LIFT_DOWN = LIFT_DOWN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  grip_lift_sequencer_if.slave bus
);

  gl_state_t   state_q, state_d;
  logic        claw_q, claw_d;
  logic [13:0] duty_q, duty_d;
  logic        hold_q, hold_d;
  logic        pick_op_q, pick_op_d;
  logic        bad_q, bad_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        rej_q, rej_d;
  logic        pick_q, drop_q;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_zero;

  logic pick_e, drop_e;

  localparam logic [TW-1:0] CLAW_LD = CLAW_T - 1'b1;
  localparam logic [TW-1:0] LIFT_LD = LIFT_T - 1'b1;

  assign pick_e = bus.pick_req & ~pick_q;
  assign drop_e = bus.drop_req & ~drop_q;

  seq_timer #(
    .TW (TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (t_load),
    .val_i  (t_val),
    .zero_o (t_zero)
  );

  always_comb begin
    state_d   = state_q;
    claw_d    = claw_q;
    duty_d    = duty_q;
    hold_d    = hold_q;
    pick_op_d = pick_op_q;
    bad_d     = bad_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    rej_d     = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_e && !hold_q) begin
          state_d   = S_OPEN;
          claw_d    = 1'b0;
          pick_op_d = 1'b1;
          bad_d     = 1'b0;
          t_load    = 1'b1;
          t_val     = CLAW_LD;
        end else if (drop_e && hold_q) begin
          state_d   = S_LOWER;
          duty_d    = LIFT_DOWN;
          pick_op_d = 1'b0;
          bad_d     = 1'b0;
          t_load    = 1'b1;
          t_val     = LIFT_LD;
        end else if (pick_e || drop_e) begin
          rej_d = 1'b1;
        end
      end

      default: begin
        rej_d = pick_e | drop_e;
        // abort leaves claw and holding as they are; only the lift moves
        if (bus.abort && state_q != S_RAISE) begin
          state_d = S_RAISE;
          duty_d  = LIFT_UP;
          bad_d   = 1'b1;
          t_load  = 1'b1;
          t_val   = LIFT_LD;
        end else if (t_zero) begin
          unique case (state_q)
            S_OPEN: begin
              state_d = S_LOWER;
              duty_d  = LIFT_DOWN;
              t_load  = 1'b1;
              t_val   = LIFT_LD;
            end
            S_LOWER: begin
              t_load = 1'b1;
              t_val  = CLAW_LD;
              if (pick_op_q) begin
                state_d = S_CLOSE;
                claw_d  = 1'b1;
              end else begin
                state_d = S_RELEASE;
                claw_d  = 1'b0;
              end
            end
            S_CLOSE: begin
              if (bus.box_present) begin
                state_d = S_RAISE;
                hold_d  = 1'b1;
                duty_d  = LIFT_UP;
                t_load  = 1'b1;
                t_val   = LIFT_LD;
              end else begin
                state_d = S_RELEASE;
                claw_d  = 1'b0;
                bad_d   = 1'b1;
                t_load  = 1'b1;
                t_val   = CLAW_LD;
              end
            end
            S_RELEASE: begin
              state_d = S_RAISE;
              hold_d  = 1'b0;
              duty_d  = LIFT_UP;
              t_load  = 1'b1;
              t_val   = LIFT_LD;
            end
            S_RAISE: begin
              state_d = S_IDLE;
              done_d  = ~bad_q;
              fail_d  = bad_q;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      claw_q    <= 1'b0;
      duty_q    <= LIFT_UP;
      hold_q    <= 1'b0;
      pick_op_q <= 1'b0;
      bad_q     <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      rej_q     <= 1'b0;
      pick_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      claw_q    <= claw_d;
      duty_q    <= duty_d;
      hold_q    <= hold_d;
      pick_op_q <= pick_op_d;
      bad_q     <= bad_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      rej_q     <= rej_d;
      pick_q    <= bus.pick_req;
      drop_q    <= bus.drop_req;
    end
  end

  assign bus.claw_close = claw_q;
  assign bus.lift_duty  = duty_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.reject     = rej_q;
  assign bus.holding    = hold_q;
  assign bus.state_dbg  = state_q;

endmodule
